instr_prefetch_queue: RTL and testbench

Parametrised instruction-fetch buffer sitting between instruction memory and the datapath's instruction register stage. It replaces the single-entry load-enable instruction register with a DEPTH-entry queue. It autonomously fetches sequential words over a request/acknowledge memory handshake and presents the oldest word with its fetch address to the decoder. A branch-redirect flush discards buffered and in-flight words.

---
 rtl/instr_prefetch_queue_pkg.sv | 14 +
 rtl/pq_fifo.sv | 81 ++++++++
 rtl/instr_prefetch_queue.sv | 123 ++++++++++++
 tb/tb_instr_prefetch_queue.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue.
//   fetch_state_e : fetch FSM states (idle / request outstanding / stale request)
//   WORD_STRIDE   : byte distance between sequential instruction words
package instr_prefetch_queue_pkg;

    typedef enum logic [1:0] {
        FS_IDLE    = 2'd0,
        FS_WAIT    = 2'd1,
        FS_DISCARD = 2'd2
    } fetch_state_e;

    localparam int unsigned WORD_STRIDE = 4;

endpackage

// File: rtl/pq_fifo.sv
// Circular {pc, word} storage for the prefetch queue.
//   CLK, CLR          : clock, asynchronous active-low reset
//   clear             : synchronous discard of all entries (wins over push/pop)
//   push, push_pc,
//   push_word         : write one entry at the tail
//   pop               : advance the head (caller guarantees count != 0)
//   head_pc, head_word: oldest entry
//   count             : number of buffered entries
module pq_fifo
    import instr_prefetch_queue_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                         CLK,
    input  logic                         CLR,
    input  logic                         clear,
    input  logic                         push,
    input  logic [ADDR_W-1:0]            push_pc,
    input  logic [DATA_W-1:0]            push_word,
    input  logic                         pop,
    output logic [ADDR_W-1:0]            head_pc,
    output logic [DATA_W-1:0]            head_word,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] word;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[tail].pc   <= push_pc;
                mem[tail].word <= push_word;
                tail           <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_pc   = mem[head].pc;
    assign head_word = mem[head].word;

    // Keeps CNT_W referenced for readers sizing external counters.
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = count;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential words ahead of the decoder.
//   CLK, CLR              : clock, asynchronous active-low reset
//   flush, flush_addr     : redirect; discards buffered/in-flight words
//   fetch_req, fetch_addr : memory read request, held until mem_ack
//   mem_ack, mem_data     : memory completion with same-cycle data
//   ir_valid, ir_out,
//   ir_pc                 : oldest buffered word and its fetch address
//   ir_take               : pop the head (ignored when ir_valid is 0)
//   level                 : number of buffered entries
module instr_prefetch_queue
    import instr_prefetch_queue_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                         CLK,
    input  logic                         CLR,
    input  logic                         flush,
    input  logic [ADDR_W-1:0]            flush_addr,
    output logic                         fetch_req,
    output logic [ADDR_W-1:0]            fetch_addr,
    input  logic                         mem_ack,
    input  logic [DATA_W-1:0]            mem_data,
    output logic                         ir_valid,
    output logic [DATA_W-1:0]            ir_out,
    output logic [ADDR_W-1:0]            ir_pc,
    input  logic                         ir_take,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_state_e       state;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  hold_pc;      // address of a request orphaned by a flush
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_after_pop;
    logic [ADDR_W-1:0]  flush_pc;
    logic               pop;
    logic               push;
    logic               space_idle;
    logic               space_wait;

    assign ir_valid        = (count != '0);
    assign pop             = ir_take && ir_valid;
    assign push            = (state == FS_WAIT) && mem_ack && !flush;
    assign count_after_pop = count - CNT_W'(pop);
    assign flush_pc        = flush_addr & ~ADDR_W'(WORD_STRIDE - 1);

    // A request reserves its slot when issued, so the ack can never overflow.
    assign space_idle = (count_after_pop < CNT_W'(DEPTH));
    assign space_wait = (count_after_pop < CNT_W'(DEPTH - 1));

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state    <= FS_IDLE;
            fetch_pc <= '0;
            hold_pc  <= '0;
        end else if (flush) begin
            fetch_pc <= flush_pc;
            case (state)
                FS_WAIT: begin
                    if (mem_ack) begin
                        state <= FS_IDLE;
                    end else begin
                        state   <= FS_DISCARD;
                        hold_pc <= fetch_pc;
                    end
                end
                // An ack arriving with the flush completes the stale request;
                // waiting on would leave the FSM expecting a second ack.
                FS_DISCARD: state <= mem_ack ? FS_IDLE : FS_DISCARD;
                default:    state <= FS_IDLE;
            endcase
        end else begin
            case (state)
                FS_IDLE: begin
                    if (space_idle) begin
                        state <= FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (mem_ack) begin
                        fetch_pc <= fetch_pc + ADDR_W'(WORD_STRIDE);
                        if (!space_wait) begin
                            state <= FS_IDLE;
                        end
                    end
                end
                FS_DISCARD: begin
                    if (mem_ack) begin
                        state <= FS_IDLE;
                    end
                end
                default: state <= FS_IDLE;
            endcase
        end
    end

    assign fetch_req  = (state != FS_IDLE);
    assign fetch_addr = (state == FS_DISCARD) ? hold_pc : fetch_pc;

    pq_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .CLR       (CLR),
        .clear     (flush),
        .push      (push),
        .push_pc   (fetch_pc),
        .push_word (mem_data),
        .pop       (pop),
        .head_pc   (ir_pc),
        .head_word (ir_out),
        .count     (count)
    );

    assign level = count;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
module tb_instr_prefetch_queue;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              CLK = 1'b0;
    logic              CLR = 1'b0;
    logic              flush = 1'b0;
    logic [7:0]        flush_addr = '0;
    logic              fetch_req;
    logic [7:0]        fetch_addr;
    logic              mem_ack = 1'b0;
    logic [31:0]       mem_data = '0;
    logic              ir_valid;
    logic [31:0]       ir_out;
    logic [7:0]        ir_pc;
    logic              ir_take = 1'b0;
    logic [2:0]        level;

    instr_prefetch_queue #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .CLK        (CLK),
        .CLR        (CLR),
        .flush      (flush),
        .flush_addr (flush_addr),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .ir_valid   (ir_valid),
        .ir_out     (ir_out),
        .ir_pc      (ir_pc),
        .ir_take    (ir_take),
        .level      (level)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: FIFO of fetched words, next sequential address, and
    // whether the outstanding request was orphaned by a redirect.
    typedef struct {
        logic [7:0]  pc;
        logic [31:0] word;
    } ent_t;

    ent_t        mq[$];
    logic [7:0]  m_next_pc;
    logic        m_stale;
    logic [7:0]  m_stale_addr;
    logic        hold_pending;
    logic [7:0]  hold_addr;

    logic        pre_req;
    logic [7:0]  pre_addr;
    logic [7:0]  pre_exp_addr;
    logic        pre_held_ok;
    logic        push_overflow;

    task automatic model_reset();
        mq.delete();
        m_next_pc     = 8'h00;
        m_stale       = 1'b0;
        m_stale_addr  = 8'h00;
        hold_pending  = 1'b0;
        hold_addr     = 8'h00;
        push_overflow = 1'b0;
    endtask

    // One clock: drive at negedge, sample pre-edge request, update model at posedge.
    task automatic step(input logic ack, input logic take, input logic fl, input logic [7:0] faddr);
        ent_t e;
        @(negedge CLK);
        mem_ack    = ack;
        ir_take    = take;
        flush      = fl;
        flush_addr = faddr;
        mem_data   = $urandom();
        #1;
        pre_req      = fetch_req;
        pre_addr     = fetch_addr;
        pre_exp_addr = m_stale ? m_stale_addr : m_next_pc;
        pre_held_ok  = !hold_pending || (fetch_req && (fetch_addr == hold_addr));
        @(posedge CLK);
        push_overflow = 1'b0;
        if (fl) begin
            mq.delete();
            if (pre_req && !ack) begin
                if (!m_stale) m_stale_addr = pre_addr;
                m_stale = 1'b1;
            end else if (pre_req && ack) begin
                m_stale = 1'b0;
            end
            m_next_pc = faddr & 8'hFC;
        end else begin
            if (take && mq.size() > 0) void'(mq.pop_front());
            if (pre_req && ack) begin
                if (m_stale) begin
                    m_stale = 1'b0;
                end else begin
                    if (mq.size() >= DEPTH) push_overflow = 1'b1;
                    e.pc   = m_next_pc;
                    e.word = mem_data;
                    mq.push_back(e);
                    m_next_pc = m_next_pc + 8'd4;
                end
            end
        end
        hold_pending = pre_req && !ack;
        hold_addr    = pre_addr;
        #1;
    endtask

    task automatic test_reset();
        CLR = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        n_checks++; if (fetch_req !== 1'b0) $display("FAIL reset_fetch_req: got %0h want 0", fetch_req); else n_pass++;
        n_checks++; if (fetch_addr !== 8'h00) $display("FAIL reset_fetch_addr: got %0h want 0", fetch_addr); else n_pass++;
        n_checks++; if (ir_valid !== 1'b0) $display("FAIL reset_ir_valid: got %0h want 0", ir_valid); else n_pass++;
        n_checks++; if (ir_out !== 32'h0) $display("FAIL reset_ir_out: got %0h want 0", ir_out); else n_pass++;
        n_checks++; if (ir_pc !== 8'h00) $display("FAIL reset_ir_pc: got %0h want 0", ir_pc); else n_pass++;
        n_checks++; if (level !== 3'd0) $display("FAIL reset_level: got %0d want 0", level); else n_pass++;
        @(negedge CLK);
        CLR = 1'b1;
        model_reset();
    endtask

    task automatic test_fill();
        logic [7:0] exp_a;
        int nreq;
        @(posedge CLK);
        #1;
        n_checks++; if (fetch_req !== 1'b1) $display("FAIL fill_first_req: got %0h want 1", fetch_req); else n_pass++;
        exp_a = 8'h00;
        nreq  = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00);
            if (pre_req) begin
                n_checks++; if (pre_addr !== exp_a) $display("FAIL fill_addr%0d: got %0h want %0h", nreq, pre_addr, exp_a); else n_pass++;
                exp_a = exp_a + 8'd4;
                nreq++;
            end
        end
        n_checks++; if (nreq != DEPTH) $display("FAIL fill_req_count: got %0d want %0d", nreq, DEPTH); else n_pass++;
        n_checks++; if (fetch_req !== 1'b0) $display("FAIL fill_req_low: got %0h want 0", fetch_req); else n_pass++;
        n_checks++; if (level !== 3'd4) $display("FAIL fill_level: got %0d want 4", level); else n_pass++;
        n_checks++; if (ir_pc !== 8'h00) $display("FAIL fill_ir_pc: got %0h want 0", ir_pc); else n_pass++;
        n_checks++; if (ir_out !== mq[0].word) $display("FAIL fill_ir_out: got %0h want %0h", ir_out, mq[0].word); else n_pass++;
    endtask

    task automatic test_take_refill();
        step(1'b1, 1'b1, 1'b0, 8'h00);
        n_checks++; if (level !== 3'd3) $display("FAIL refill_level3: got %0d want 3", level); else n_pass++;
        n_checks++; if (fetch_req !== 1'b1) $display("FAIL refill_req: got %0h want 1", fetch_req); else n_pass++;
        n_checks++; if (fetch_addr !== 8'h10) $display("FAIL refill_addr: got %0h want 10", fetch_addr); else n_pass++;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        n_checks++; if (level !== 3'd4) $display("FAIL refill_level4: got %0d want 4", level); else n_pass++;
        n_checks++; if (fetch_req !== 1'b0) $display("FAIL refill_req_low: got %0h want 0", fetch_req); else n_pass++;
        n_checks++; if (ir_pc !== 8'h04) $display("FAIL refill_ir_pc: got %0h want 04", ir_pc); else n_pass++;
    endtask

    task automatic test_back_to_back();
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        n_checks++; if (level !== 3'd2) $display("FAIL b2b_pre_level: got %0d want 2", level); else n_pass++;
        n_checks++; if (ir_pc !== 8'h0C) $display("FAIL b2b_pre_pc: got %0h want 0c", ir_pc); else n_pass++;
        step(1'b1, 1'b1, 1'b0, 8'h00);
        n_checks++; if (level !== 3'd2) $display("FAIL b2b_level: got %0d want 2", level); else n_pass++;
        n_checks++; if (ir_pc !== 8'h10) $display("FAIL b2b_ir_pc: got %0h want 10", ir_pc); else n_pass++;
        n_checks++; if (fetch_addr !== 8'h18) $display("FAIL b2b_next_addr: got %0h want 18", fetch_addr); else n_pass++;
        step(1'b0, 1'b1, 1'b0, 8'h00);
        n_checks++; if (ir_pc !== 8'h14) $display("FAIL b2b_tail_pc: got %0h want 14", ir_pc); else n_pass++;
        n_checks++; if (ir_out !== mq[0].word) $display("FAIL b2b_tail_word: got %0h want %0h", ir_out, mq[0].word); else n_pass++;
    endtask

    task automatic test_flush();
        n_checks++; if (fetch_req !== 1'b1 || fetch_addr !== 8'h18) $display("FAIL flush_pre: got req %0h addr %0h want 1 18", fetch_req, fetch_addr); else n_pass++;
        step(1'b0, 1'b0, 1'b1, 8'h43);
        n_checks++; if (ir_valid !== 1'b0) $display("FAIL flush_valid: got %0h want 0", ir_valid); else n_pass++;
        n_checks++; if (level !== 3'd0) $display("FAIL flush_level: got %0d want 0", level); else n_pass++;
        n_checks++; if (fetch_req !== 1'b1) $display("FAIL flush_req_held: got %0h want 1", fetch_req); else n_pass++;
        n_checks++; if (fetch_addr !== 8'h18) $display("FAIL flush_addr_held: got %0h want 18", fetch_addr); else n_pass++;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        n_checks++; if (ir_valid !== 1'b0) $display("FAIL flush_drop: got valid %0h want 0", ir_valid); else n_pass++;
        n_checks++; if (fetch_req !== 1'b0) $display("FAIL flush_idle: got req %0h want 0", fetch_req); else n_pass++;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        n_checks++; if (fetch_req !== 1'b1 || fetch_addr !== 8'h40) $display("FAIL flush_new_req: got req %0h addr %0h want 1 40", fetch_req, fetch_addr); else n_pass++;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        n_checks++; if (ir_valid !== 1'b1 || ir_pc !== 8'h40) $display("FAIL flush_first_pc: got valid %0h pc %0h want 1 40", ir_valid, ir_pc); else n_pass++;
        n_checks++; if (ir_out !== mq[0].word) $display("FAIL flush_first_word: got %0h want %0h", ir_out, mq[0].word); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [7:0] seen[$];
        int guard;
        step(1'b0, 1'b0, 1'b1, 8'hF8);
        guard = 0;
        while (level != 3'd3 && guard < 12) begin
            step(1'b1, 1'b0, 1'b0, 8'h00);
            if (pre_req) seen.push_back(pre_addr);
            guard++;
        end
        n_checks++; if (level !== 3'd3) $display("FAIL wrap_timeout: got level %0d want 3", level); else n_pass++;
        if (seen.size() >= 3) begin
            n_checks++; if (seen[seen.size()-3] !== 8'hF8) $display("FAIL wrap_addr_f8: got %0h want f8", seen[seen.size()-3]); else n_pass++;
            n_checks++; if (seen[seen.size()-2] !== 8'hFC) $display("FAIL wrap_addr_fc: got %0h want fc", seen[seen.size()-2]); else n_pass++;
            n_checks++; if (seen[seen.size()-1] !== 8'h00) $display("FAIL wrap_addr_00: got %0h want 00", seen[seen.size()-1]); else n_pass++;
        end else begin
            n_checks++; $display("FAIL wrap_seen: got %0d requests want >= 3", seen.size());
        end
        n_checks++; if (fetch_addr !== 8'h04) $display("FAIL wrap_next: got %0h want 04", fetch_addr); else n_pass++;
        n_checks++; if (ir_pc !== 8'hF8) $display("FAIL wrap_head_pc: got %0h want f8", ir_pc); else n_pass++;
    endtask

    task automatic test_reset_mid();
        mem_ack = 1'b0; ir_take = 1'b0; flush = 1'b0;
        n_checks++; if (level !== 3'd3 || fetch_req !== 1'b1) $display("FAIL rstmid_pre: got level %0d req %0h want 3 1", level, fetch_req); else n_pass++;
        @(negedge CLK);
        #2 CLR = 1'b0;
        #1;
        n_checks++; if (fetch_req !== 1'b0) $display("FAIL rstmid_req: got %0h want 0", fetch_req); else n_pass++;
        n_checks++; if (fetch_addr !== 8'h00) $display("FAIL rstmid_addr: got %0h want 0", fetch_addr); else n_pass++;
        n_checks++; if (ir_valid !== 1'b0) $display("FAIL rstmid_valid: got %0h want 0", ir_valid); else n_pass++;
        n_checks++; if (ir_out !== 32'h0) $display("FAIL rstmid_out: got %0h want 0", ir_out); else n_pass++;
        n_checks++; if (ir_pc !== 8'h00) $display("FAIL rstmid_pc: got %0h want 0", ir_pc); else n_pass++;
        n_checks++; if (level !== 3'd0) $display("FAIL rstmid_level: got %0d want 0", level); else n_pass++;
        @(negedge CLK);
        CLR = 1'b1;
        model_reset();
        @(posedge CLK);
        #1;
        n_checks++; if (fetch_req !== 1'b1 || fetch_addr !== 8'h00) $display("FAIL rstmid_restart: got req %0h addr %0h want 1 0", fetch_req, fetch_addr); else n_pass++;
        step(1'b1, 1'b0, 1'b0, 8'h00);
        n_checks++; if (ir_valid !== 1'b1 || ir_pc !== 8'h00 || level !== 3'd1) $display("FAIL rstmid_first: got valid %0h pc %0h level %0d want 1 0 1", ir_valid, ir_pc, level); else n_pass++;
    endtask

    task automatic test_random();
        logic a, t, f;
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 1) == 1);
            t = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 15) == 0);
            step(a, t, f, 8'($urandom()));
            n_checks++; if (!pre_held_ok) $display("FAIL rnd_req_hold[%0d]: got req %0h addr %0h want 1 %0h", i, pre_req, pre_addr, hold_addr); else n_pass++;
            if (pre_req) begin
                n_checks++; if (pre_addr !== pre_exp_addr) $display("FAIL rnd_fetch_addr[%0d]: got %0h want %0h", i, pre_addr, pre_exp_addr); else n_pass++;
            end
            n_checks++; if (push_overflow) $display("FAIL rnd_overflow[%0d]: got push into full queue want none", i); else n_pass++;
            n_checks++; if (level !== 3'(mq.size())) $display("FAIL rnd_level[%0d]: got %0d want %0d", i, level, mq.size()); else n_pass++;
            n_checks++; if (ir_valid !== (mq.size() > 0)) $display("FAIL rnd_valid[%0d]: got %0h want %0h", i, ir_valid, mq.size() > 0); else n_pass++;
            if (mq.size() > 0) begin
                n_checks++; if (ir_pc !== mq[0].pc || ir_out !== mq[0].word) $display("FAIL rnd_head[%0d]: got %0h/%0h want %0h/%0h", i, ir_pc, ir_out, mq[0].pc, mq[0].word); else n_pass++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_take_refill();
        test_back_to_back();
        test_flush();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
